// File: rtl/cordic_pkg.sv
// cordic_pkg: shared definitions for the rotation-mode CORDIC.
//   - state_e   : controller states (COMP is only reachable when the
//                 CORDIC_GAIN_COMP_EN build macro is defined)
//   - ANGLE_90 / ANGLE_180 : quarter and half turn in 32-bit binary angle units
//   - INV_GAIN  : 1/K in Q2.30, used by the optional gain compensation
//   - atan_ang(): micro-rotation angle table, rescaled to any angle width
package cordic_pkg;

  localparam logic [31:0] ANGLE_90  = 32'h4000_0000;
  localparam logic [31:0] ANGLE_180 = 32'h8000_0000;

  // round(0.6072529350 * 2^30)
  localparam logic signed [31:0] INV_GAIN = 32'sd652032874;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    COMP   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // round(atan(2^-i) / (2*pi) * 2^32)
  function automatic logic [31:0] atan32(input int i);
    logic [31:0] a;
    case (i)
      0:  a = 32'd536870912;
      1:  a = 32'd316933406;
      2:  a = 32'd167458907;
      3:  a = 32'd85004756;
      4:  a = 32'd42667331;
      5:  a = 32'd21354465;
      6:  a = 32'd10679838;
      7:  a = 32'd5340245;
      8:  a = 32'd2670163;
      9:  a = 32'd1335087;
      10: a = 32'd667544;
      11: a = 32'd333772;
      12: a = 32'd166886;
      13: a = 32'd83443;
      14: a = 32'd41722;
      15: a = 32'd20861;
      16: a = 32'd10430;
      17: a = 32'd5215;
      18: a = 32'd2608;
      19: a = 32'd1304;
      20: a = 32'd652;
      21: a = 32'd326;
      22: a = 32'd163;
      23: a = 32'd81;
      24: a = 32'd41;
      25: a = 32'd20;
      26: a = 32'd10;
      27: a = 32'd5;
      28: a = 32'd3;
      29: a = 32'd1;
      30: a = 32'd1;
      default: a = 32'd0;
    endcase
    return a;
  endfunction

  // Table entry rescaled from 32-bit angle units to ang_w-bit units
  // (round-half-up when narrowing). Caller truncates to its angle width.
  function automatic logic [63:0] atan_ang(input int i, input int ang_w);
    logic [63:0] v;
    v = {32'd0, atan32(i)};
    if (ang_w >= 32) begin
      return v << (ang_w - 32);
    end
    return (v + (64'd1 << (31 - ang_w))) >> (32 - ang_w);
  endfunction

endpackage

// File: rtl/cordic_sat.sv
// cordic_sat: signed saturating truncation from IN_W to OUT_W bits.
//   din  : signed IN_W-bit value
//   dout : din clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
module cordic_sat #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] sat(input logic signed [IN_W-1:0] v);
    // Representable iff every dropped bit equals the kept sign bit.
    if ((&v[IN_W-1:OUT_W-1]) || !(|v[IN_W-1:OUT_W-1])) begin
      return v[OUT_W-1:0];
    end
    return v[IN_W-1] ? SAT_MIN : SAT_MAX;
  endfunction

  assign dout = sat(din);

endmodule

// File: rtl/cordic_rotate.sv
// cordic_rotate: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Rotates (x_in, y_in) by z_in; with y_in = 0 it turns polar (x_in = magnitude,
// z_in = angle) back into Cartesian form.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (accepted only in IDLE)
//   x_in, y_in           : signed operands, |v| < 2^(DATA_W-2)
//   z_in                 : rotation angle, binary angle units (2^ANG_W = 360 deg)
//   out_valid / out_ready: result handshake; results held until taken
//   x_out, y_out         : saturated rotated vector
// Build macro CORDIC_GAIN_COMP_EN: adds a COMP state multiplying by 1/K so the
// outputs are unity gain (latency ITER+1 instead of ITER). Undefined: outputs
// carry the CORDIC gain K.
module cordic_rotate
  import cordic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ANG_W  = 32,
  parameter int ITER   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic        [ANG_W-1:0]  z_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out
);

  // Two guard bits cover the gain K ~= 1.647 on |v| < 2^(DATA_W-2).
  localparam int XW    = DATA_W + 2;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [63:0]      A90_W  = {ANGLE_90, 32'd0};
  localparam logic [63:0]      A180_W = {ANGLE_180, 32'd0};
  localparam logic [ANG_W-1:0] ANG_90  = A90_W[63 -: ANG_W];
  localparam logic [ANG_W-1:0] ANG_180 = A180_W[63 -: ANG_W];

  state_e                  state_q, state_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic        [ANG_W-1:0] z_q, z_d;
  logic        [CNT_W-1:0] i_q, i_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;

  logic signed [XW-1:0]    x_ext, y_ext, x_sh, y_sh, x_rot, y_rot;
  logic        [ANG_W-1:0] z_plus90, atan_i, z_rot;
  logic                    quad_flip;
  logic signed [DATA_W-1:0] x_sat, y_sat;

  always_comb begin
    x_ext    = XW'(x_in);
    y_ext    = XW'(y_in);
    // z in [90,270) deg exactly when z + 90 deg lands in the upper half-turn.
    z_plus90  = z_in + ANG_90;
    quad_flip = z_plus90[ANG_W-1];

    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    atan_i = ANG_W'(atan_ang(int'(i_q), ANG_W));
    if (!z_q[ANG_W-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_i;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_i;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = XW + 32;
  logic signed [PW-1:0] x_prod, y_prod, x_sat_in, y_sat_in;

  // Q2.30 scaling by 1/K with round-half-up before the shift.
  always_comb begin
    x_prod   = PW'(x_q) * PW'(INV_GAIN);
    y_prod   = PW'(y_q) * PW'(INV_GAIN);
    x_sat_in = (x_prod + (PW'(1) <<< 29)) >>> 30;
    y_sat_in = (y_prod + (PW'(1) <<< 29)) >>> 30;
  end
`else
  localparam int PW = XW;
  logic signed [PW-1:0] x_sat_in, y_sat_in;

  // Final micro-rotation result feeds the output registers directly.
  always_comb begin
    x_sat_in = x_rot;
    y_sat_in = y_rot;
  end
`endif

  cordic_sat #(.IN_W(PW), .OUT_W(DATA_W)) u_sat_x (.din(x_sat_in), .dout(x_sat));
  cordic_sat #(.IN_W(PW), .OUT_W(DATA_W)) u_sat_y (.din(y_sat_in), .dout(y_sat));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d        = quad_flip ? -x_ext : x_ext;
          y_d        = quad_flip ? -y_ext : y_ext;
          z_d        = quad_flip ? z_in + ANG_180 : z_in;
          i_d        = '0;
          in_ready_d = 1'b0;
          state_d    = ROTATE;
        end
      end
      ROTATE: begin
        x_d = x_rot;
        y_d = y_rot;
        z_d = z_rot;
        i_d = i_q + CNT_W'(1);
        if (i_q == CNT_W'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = COMP;
`else
          x_out_d     = x_sat;
          y_out_d     = y_sat;
          out_valid_d = 1'b1;
          state_d     = DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      COMP: begin
        x_out_d     = x_sat;
        y_out_d     = y_sat;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      i_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      i_q         <= i_d;
    end
    x_q <= x_d;
    y_q <= y_d;
    z_q <= z_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;

endmodule

// File: tb/tb_cordic_rotate.sv
`timescale 1ns/1ps
module tb_cordic_rotate;
  import cordic_pkg::*;

  localparam int DATA_W = 32;
  localparam int ANG_W  = 32;
  localparam int ITER   = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
`else
  localparam int LAT = ITER;
`endif
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [DATA_W-1:0] y_in = '0;
  logic        [ANG_W-1:0]  z_in = '0;
  logic signed [DATA_W-1:0] x_out, y_out;

  int  vectors = 0;
  int  miscompares = 0;
  real gain;
  real q_ex[$];
  real q_ey[$];
  real q_tol[$];

  cordic_rotate #(.DATA_W(DATA_W), .ANG_W(ANG_W), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic real model_gain();
    real k;
    k = 1.0;
    for (int i = 0; i < ITER; i++) k = k * $sqrt(1.0 + $pow(2.0, -2.0 * i));
`ifdef CORDIC_GAIN_COMP_EN
    k = k * real'(INV_GAIN) / 1073741824.0;
`endif
    return k;
  endfunction

  function automatic real clamp(input real v);
    if (v > 2147483647.0) return 2147483647.0;
    if (v < -2147483648.0) return -2147483648.0;
    return v;
  endfunction

  // Ideal rotation; tolerance = residual-angle bound of the last micro-rotation
  // on the output magnitude, plus a few LSBs of truncation.
  task automatic push_expected(input int xi, input int yi, input logic [31:0] zi);
    real th, m;
    th = real'($signed(zi)) * 2.0 * PI / 4294967296.0;
    q_ex.push_back(clamp(gain * (real'(xi) * $cos(th) - real'(yi) * $sin(th))));
    q_ey.push_back(clamp(gain * (real'(xi) * $sin(th) + real'(yi) * $cos(th))));
    m = gain * $sqrt(real'(xi) * real'(xi) + real'(yi) * real'(yi));
    q_tol.push_back(m * $pow(2.0, -(ITER - 1.0)) + ITER + 8.0);
  endtask

  // Called at a negedge with in_ready high; returns at the negedge after accept.
  task automatic send(input int xi, input int yi, input logic [31:0] zi);
    x_in = xi; y_in = yi; z_in = zi; in_valid = 1'b1;
    @(posedge clk);
    push_expected(xi, yi, zi);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); @(negedge clk); n++;
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    vectors++;
    if (x_out !== 32'sd0 || y_out !== 32'sd0) begin
      miscompares++;
      $display("FAIL reset_data: x_out=%0d y_out=%0d, want 0/0", x_out, y_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_angles();
    logic [31:0] zt [5];
    string nm [5];
    int n;
    real ex, ey, tol, dx, dy;
    zt = '{32'h0000_0000, ANGLE_90, ANGLE_180, 32'h1555_5555, 32'hEAAA_AAAB};
    nm = '{"ang0", "ang90", "ang180", "ang30", "angm30"};
    for (int k = 0; k < 5; k++) begin
      send(1048576, 0, zt[k]);
      wait_out(n);
      ex = q_ex.pop_front(); ey = q_ey.pop_front(); tol = q_tol.pop_front();
      vectors++;
      if (n !== LAT) begin
        miscompares++;
        $display("FAIL %s latency: %0d edges, want %0d", nm[k], n, LAT);
      end
      dx = real'(x_out) - ex;
      dy = real'(y_out) - ey;
      vectors++;
      if (dx > tol || dx < -tol) begin
        miscompares++;
        $display("FAIL %s x_out: got %0d, want %0.1f +/- %0.1f", nm[k], x_out, ex, tol);
      end
      vectors++;
      if (dy > tol || dy < -tol) begin
        miscompares++;
        $display("FAIL %s y_out: got %0d, want %0.1f +/- %0.1f", nm[k], y_out, ey, tol);
      end
      take_output();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL %s release: out_valid=%b in_ready=%b, want 0/1", nm[k], out_valid, in_ready);
      end
    end
  endtask

  task automatic test_zero_vector();
    int n;
    real ex, ey, tol;
    send(0, 0, 32'h3000_0000);
    wait_out(n);
    ex = q_ex.pop_front(); ey = q_ey.pop_front(); tol = q_tol.pop_front();
    vectors++;
    if (n !== LAT || x_out !== 32'sd0 || y_out !== 32'sd0) begin
      miscompares++;
      $display("FAIL zero_vec: lat=%0d x=%0d y=%0d, want lat=%0d x=%0.0f y=%0.0f", n, x_out, y_out, LAT, ex, ey);
    end
    take_output();
  endtask

  task automatic test_saturation();
    int n;
    real ex, ey, tol, dx, dy;
    send(1073741823, 1073741823, 32'h2000_0000);
    wait_out(n);
    ex = q_ex.pop_front(); ey = q_ey.pop_front(); tol = q_tol.pop_front();
    dx = real'(x_out) - ex;
    dy = real'(y_out) - ey;
    vectors++;
    if (dx > tol || dx < -tol) begin
      miscompares++;
      $display("FAIL sat x_out: got %0d, want %0.1f +/- %0.1f", x_out, ex, tol);
    end
    vectors++;
    if (dy > tol || dy < -tol) begin
      miscompares++;
      $display("FAIL sat y_out: got %0d, want %0.1f +/- %0.1f", y_out, ey, tol);
    end
`ifndef CORDIC_GAIN_COMP_EN
    vectors++;
    if (y_out !== 32'sh7FFF_FFFF) begin
      miscompares++;
      $display("FAIL sat_clamp: y_out=%0d, want %0d", y_out, 32'sh7FFF_FFFF);
    end
`endif
    take_output();
  endtask

  task automatic test_backpressure();
    int n;
    logic signed [DATA_W-1:0] hx, hy;
    real ex, ey, tol, dx, dy;
    send(300000, -200000, 32'h2000_0000);
    wait_out(n);
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_valid: out_valid=%b after %0d edges, want 1", out_valid, n);
    end
    hx = x_out; hy = y_out;
    // New operands offered while the result is waiting.
    x_in = 400000; y_in = 100000; z_in = 32'h0AAA_AAAB; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || x_out !== hx || y_out !== hy) begin
        miscompares++;
        $display("FAIL bp_hold c%0d: valid=%b ready=%b x=%0d y=%0d, want 1/0 x=%0d y=%0d",
                 c, out_valid, in_ready, x_out, y_out, hx, hy);
      end
    end
    ex = q_ex.pop_front(); ey = q_ey.pop_front(); tol = q_tol.pop_front();
    dx = real'(x_out) - ex;
    dy = real'(y_out) - ey;
    vectors++;
    if (dx > tol || dx < -tol || dy > tol || dy < -tol) begin
      miscompares++;
      $display("FAIL bp_result: got %0d,%0d want %0.1f,%0.1f +/- %0.1f", x_out, y_out, ex, ey, tol);
    end
    take_output();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    end
    // The held in_valid is taken on this edge.
    @(posedge clk);
    push_expected(400000, 100000, 32'h0AAA_AAAB);
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: in_ready=%b, want 0", in_ready);
    end
    wait_out(n);
    ex = q_ex.pop_front(); ey = q_ey.pop_front(); tol = q_tol.pop_front();
    dx = real'(x_out) - ex;
    dy = real'(y_out) - ey;
    vectors++;
    if (n !== LAT || dx > tol || dx < -tol || dy > tol || dy < -tol) begin
      miscompares++;
      $display("FAIL bp_second: lat=%0d got %0d,%0d want lat=%0d %0.1f,%0.1f +/- %0.1f",
               n, x_out, y_out, LAT, ex, ey, tol);
    end
    take_output();
  endtask

  task automatic test_reset_mid_op();
    int n;
    real ex, ey, tol, dx, dy, drop;
    bit seen;
    send(1048576, 0, 32'h1555_5555);
    repeat (5) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    drop = q_ex.pop_back(); drop = q_ey.pop_back(); drop = q_tol.pop_back();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || x_out !== 32'sd0 || y_out !== 32'sd0) begin
      miscompares++;
      $display("FAIL midrst_state: valid=%b ready=%b x=%0d y=%0d, want 0/1/0/0", out_valid, in_ready, x_out, y_out);
    end
    seen = 1'b0;
    for (int c = 0; c < ITER + 4; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_no_output: out_valid seen=%b, want 0", seen);
    end
    send(-700000, 250000, 32'hC000_0000);
    wait_out(n);
    ex = q_ex.pop_front(); ey = q_ey.pop_front(); tol = q_tol.pop_front();
    dx = real'(x_out) - ex;
    dy = real'(y_out) - ey;
    vectors++;
    if (n !== LAT || dx > tol || dx < -tol || dy > tol || dy < -tol) begin
      miscompares++;
      $display("FAIL midrst_after: lat=%0d got %0d,%0d want lat=%0d %0.1f,%0.1f +/- %0.1f",
               n, x_out, y_out, LAT, ex, ey, tol);
    end
    take_output();
  endtask

  task automatic test_back_to_back();
    localparam int N = 4;
    int sent, got, c, last_acc, rx, ry;
    logic [31:0] rz;
    bit acc;
    real ex, ey, tol, dx, dy;
    sent = 0; got = 0; c = 0; last_acc = -1;
    out_ready = 1'b1;
    while ((sent < N || got < sent) && c < 400) begin
      if (out_valid) begin
        ex = q_ex.pop_front(); ey = q_ey.pop_front(); tol = q_tol.pop_front();
        dx = real'(x_out) - ex;
        dy = real'(y_out) - ey;
        vectors++;
        if (dx > tol || dx < -tol || dy > tol || dy < -tol) begin
          miscompares++;
          $display("FAIL b2b_result%0d: got %0d,%0d want %0.1f,%0.1f +/- %0.1f", got, x_out, y_out, ex, ey, tol);
        end
        got++;
      end
      acc = 1'b0;
      if (in_ready && sent < N) begin
        rx = int'($urandom_range(0, 2000000)) - 1000000;
        ry = int'($urandom_range(0, 2000000)) - 1000000;
        rz = $urandom;
        x_in = rx; y_in = ry; z_in = rz; in_valid = 1'b1;
        acc = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      if (acc) begin
        push_expected(rx, ry, rz);
        if (last_acc >= 0) begin
          vectors++;
          if (c - last_acc !== LAT + 2) begin
            miscompares++;
            $display("FAIL b2b_interval: %0d cycles between accepts, want %0d", c - last_acc, LAT + 2);
          end
        end
        last_acc = c;
        sent++;
      end
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (got !== N) begin
      miscompares++;
      $display("FAIL b2b_count: %0d results, want %0d", got, N);
    end
  endtask

  initial begin
    gain = model_gain();
    @(negedge clk);
    test_reset();
    test_angles();
    test_zero_vector();
    test_saturation();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
